// File: rtl/mem_reg_mp.sv
// mem_reg_mp: multi-port register file with R0 hardwired to zero and per-register pending bits.
// Define MEM_REG_BYPASS_EN to forward same-cycle write data (and clear busy) to the read ports.
module mem_reg_mp #(
    parameter int p_WORD_LEN      = 16,
    parameter int p_REG_ADDR_LEN  = 3,
    parameter int p_REG_FILE_SIZE = 8,
    parameter int p_READ_PORTS    = 2,
    parameter int p_WRITE_PORTS   = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [p_READ_PORTS*p_REG_ADDR_LEN-1:0] rd_addr,
    output logic [p_READ_PORTS*p_WORD_LEN-1:0]     rd_data,
    output logic [p_READ_PORTS-1:0]                rd_busy,
    input  logic [p_WRITE_PORTS-1:0]               wr_en,
    input  logic [p_WRITE_PORTS*p_REG_ADDR_LEN-1:0] wr_addr,
    input  logic [p_WRITE_PORTS*p_WORD_LEN-1:0]    wr_data,
    input  logic                                   rsv_en,
    input  logic [p_REG_ADDR_LEN-1:0]              rsv_addr,
    output logic [p_REG_FILE_SIZE-1:0]             busy_vec
);
    localparam int W = p_WORD_LEN;
    localparam int A = p_REG_ADDR_LEN;
    localparam int S = p_REG_FILE_SIZE;

    logic [W-1:0] regs_q [S];
    logic [W-1:0] regs_d [S];
    logic [S-1:0] busy_q, busy_d;

    function automatic logic valid_addr(input logic [A-1:0] a);
        return (a != '0) && (int'(a) < S);
    endfunction

    // Later ports overwrite earlier ones, so the highest-index port wins a collision;
    // the reserve is applied last so a new producer beats a retiring one.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int j = 0; j < p_WRITE_PORTS; j++) begin
            if (wr_en[j] && valid_addr(wr_addr[j*A +: A])) begin
                regs_d[wr_addr[j*A +: A]] = wr_data[j*W +: W];
                busy_d[wr_addr[j*A +: A]] = 1'b0;
            end
        end
        if (rsv_en && valid_addr(rsv_addr))
            busy_d[rsv_addr] = 1'b1;
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < S; i++)
                regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < p_READ_PORTS; k++) begin
            if (valid_addr(rd_addr[k*A +: A])) begin
                rd_data[k*W +: W] = regs_q[rd_addr[k*A +: A]];
                rd_busy[k]        = busy_q[rd_addr[k*A +: A]];
`ifdef MEM_REG_BYPASS_EN
                for (int j = 0; j < p_WRITE_PORTS; j++) begin
                    if (wr_en[j] && wr_addr[j*A +: A] == rd_addr[k*A +: A]) begin
                        rd_data[k*W +: W] = wr_data[j*W +: W];
                        rd_busy[k] = rsv_en && rsv_addr == rd_addr[k*A +: A] && busy_q[rd_addr[k*A +: A]];
                    end
                end
`endif
            end
        end
    end

    assign busy_vec = busy_q;
endmodule
